iob_axi_ram_responder: RTL and testbench

//  AXI4 slave (responder) that answers the SoC's external-memory AXI master. It serves the

---
 rtl/iob_axi_ram_responder.sv | 201 ++++++++++++++++++++
 tb/tb_iob_axi_ram_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi_ram_responder.sv
// AXI4 slave serving one burst at a time from a single-port synchronous RAM with 1-cycle read latency.
// Reads stream at one beat per cycle through a 2-entry output FIFO.
module iob_axi_ram_responder #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32
) (
    input  logic                                          clk_i,
    input  logic                                          arst_n_i,
    input  logic [AXI_ID_W-1:0]                           axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]                         axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]                          axi_awlen_i,
    input  logic [2:0]                                    axi_awsize_i,
    input  logic [1:0]                                    axi_awburst_i,
    input  logic                                          axi_awvalid_i,
    output logic                                          axi_awready_o,
    input  logic [AXI_DATA_W-1:0]                         axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0]                       axi_wstrb_i,
    input  logic                                          axi_wlast_i,
    input  logic                                          axi_wvalid_i,
    output logic                                          axi_wready_o,
    output logic [AXI_ID_W-1:0]                           axi_bid_o,
    output logic [1:0]                                    axi_bresp_o,
    output logic                                          axi_bvalid_o,
    input  logic                                          axi_bready_i,
    input  logic [AXI_ID_W-1:0]                           axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]                         axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]                          axi_arlen_i,
    input  logic [2:0]                                    axi_arsize_i,
    input  logic [1:0]                                    axi_arburst_i,
    input  logic                                          axi_arvalid_i,
    output logic                                          axi_arready_o,
    output logic [AXI_ID_W-1:0]                           axi_rid_o,
    output logic [AXI_DATA_W-1:0]                         axi_rdata_o,
    output logic [1:0]                                    axi_rresp_o,
    output logic                                          axi_rlast_o,
    output logic                                          axi_rvalid_o,
    input  logic                                          axi_rready_i,
    output logic                                          ram_en_o,
    output logic [AXI_DATA_W/8-1:0]                       ram_we_o,
    output logic [AXI_ADDR_W-$clog2(AXI_DATA_W/8)-1:0]    ram_addr_o,
    output logic [AXI_DATA_W-1:0]                         ram_d_o,
    input  logic [AXI_DATA_W-1:0]                         ram_d_i
);
    localparam int NB   = AXI_DATA_W / 8;
    localparam int NB_W = $clog2(NB);
    localparam logic [2:0] SIZE_FULL   = 3'(NB_W);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WR_DATA   = 2'd1;
    localparam logic [1:0] ST_WR_RESP   = 2'd2;
    localparam logic [1:0] ST_RD_STREAM = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic                  fixed;
    } req_t;

    logic [1:0]           state_q;
    req_t                 req_q;
    logic                 err_q;
    logic                 prio_wr_q;
    logic [AXI_LEN_W:0]   cnt_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [1:0][AXI_DATA_W-1:0] fifo_data_q;
    logic [1:0]           fifo_last_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           fifo_cnt_q;

    logic aw_fire, ar_fire, aw_err, ar_err;
    logic w_fire, w_in_len, w_short, wr_en;
    logic rd_pop, rd_issue_stream, rd_issue, issue_last;
    logic [2:0] occ;
    logic [AXI_LEN_W:0] len_ext;

    function automatic logic [AXI_ADDR_W-1:0] step_addr(input logic [AXI_ADDR_W-1:0] a,
                                                        input logic fixed);
        return fixed ? a : a + AXI_ADDR_W'(NB);
    endfunction

    assign len_ext = {1'b0, req_q.len};
    assign aw_err  = axi_awsize_i != SIZE_FULL;
    assign ar_err  = axi_arsize_i != SIZE_FULL;

    // Write wins a same-cycle tie only when it holds priority; priority flips on every accept.
    assign axi_awready_o = (state_q == ST_IDLE) & axi_awvalid_i & (~axi_arvalid_i | prio_wr_q);
    assign axi_arready_o = (state_q == ST_IDLE) & axi_arvalid_i & ~axi_awready_o;
    assign aw_fire = axi_awvalid_i & axi_awready_o;
    assign ar_fire = axi_arvalid_i & axi_arready_o;

    assign axi_wready_o = state_q == ST_WR_DATA;
    assign w_fire   = axi_wvalid_i & axi_wready_o;
    assign w_in_len = cnt_q <= len_ext;
    assign w_short  = cnt_q < len_ext;
    assign wr_en    = w_fire & w_in_len & ~err_q;

    assign axi_bvalid_o = state_q == ST_WR_RESP;
    assign axi_bid_o    = req_q.id;
    assign axi_bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;

    // Beat 0 is issued straight off the AR handshake so rvalid lands two cycles later.
    assign rd_pop          = axi_rvalid_o & axi_rready_i;
    assign occ             = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign rd_issue_stream = (state_q == ST_RD_STREAM) & (cnt_q <= len_ext)
                           & (occ < (3'd2 + {2'b00, rd_pop}));
    assign rd_issue        = rd_issue_stream | ar_fire;
    assign issue_last      = ar_fire ? (axi_arlen_i == '0) : (cnt_q == len_ext);

    assign ram_en_o   = wr_en | (rd_issue_stream & ~err_q) | (ar_fire & ~ar_err);
    assign ram_we_o   = wr_en ? axi_wstrb_i : '0;
    assign ram_d_o    = wr_en ? axi_wdata_i : '0;
    assign ram_addr_o = ar_fire ? axi_araddr_i[AXI_ADDR_W-1:NB_W] : req_q.addr[AXI_ADDR_W-1:NB_W];

    assign axi_rvalid_o = fifo_cnt_q != 2'd0;
    assign axi_rdata_o  = fifo_data_q[rd_ptr_q];
    assign axi_rlast_o  = fifo_last_q[rd_ptr_q];
    assign axi_rid_o    = req_q.id;
    assign axi_rresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            err_q     <= 1'b0;
            prio_wr_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_fire) begin
                        req_q.id    <= axi_awid_i;
                        req_q.addr  <= axi_awaddr_i;
                        req_q.len   <= axi_awlen_i;
                        req_q.fixed <= axi_awburst_i == BURST_FIXED;
                        err_q       <= aw_err;
                        cnt_q       <= '0;
                        prio_wr_q   <= ~prio_wr_q;
                        state_q     <= ST_WR_DATA;
                    end else if (ar_fire) begin
                        req_q.id    <= axi_arid_i;
                        req_q.addr  <= step_addr(axi_araddr_i, axi_arburst_i == BURST_FIXED);
                        req_q.len   <= axi_arlen_i;
                        req_q.fixed <= axi_arburst_i == BURST_FIXED;
                        err_q       <= ar_err;
                        cnt_q       <= AXI_LEN_W'(1) + (AXI_LEN_W+1)'(0);
                        prio_wr_q   <= ~prio_wr_q;
                        state_q     <= ST_RD_STREAM;
                    end
                end
                ST_WR_DATA: begin
                    if (w_fire) begin
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        req_q.addr <= step_addr(req_q.addr, req_q.fixed);
                        if (!w_in_len || (axi_wlast_i && w_short)) err_q <= 1'b1;
                        if (axi_wlast_i) state_q <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bready_i) state_q <= ST_IDLE;
                end
                default: begin
                    if (rd_issue_stream) begin
                        cnt_q      <= cnt_q + 1'b1;
                        req_q.addr <= step_addr(req_q.addr, req_q.fixed);
                    end
                    if (rd_pop && axi_rlast_o) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Errored reads flow through the same pipe with zero data, so timing is identical.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q     <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            inflight_q      <= rd_issue;
            inflight_last_q <= issue_last;
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= err_q ? '0 : ram_d_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (rd_pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, rd_pop};
        end
    end
endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Directed bench for iob_axi_ram_responder: behavioural RAM, write log and per-scenario checks.
module tb_iob_axi_ram_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awid, arid, bid, rid;
    logic [23:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [21:0] ram_addr;
    logic [31:0] ram_d;
    logic [31:0] ram_q = '0;

    iob_axi_ram_responder dut (
        .clk_i(clk), .arst_n_i(rst_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
        .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
        .ram_d_i(ram_q)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int outst = 0;
    int max_out = 0;
    logic [31:0] mem [0:1023];
    logic [57:0] wr_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'd0) ram_q <= mem[ram_addr[9:0]];
            else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr[9:0]][b*8 +: 8] <= ram_d[b*8 +: 8];
                wr_log.push_back({ram_addr, ram_d, ram_we});
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst <= 0;
        else outst <= outst + ((ram_en && ram_we == 4'd0) ? 1 : 0) - ((rvalid && rready) ? 1 : 0);
    end

    logic [31:0] rq_data [$];
    logic        rq_last [$];
    logic [1:0]  rq_resp [$];
    logic [3:0]  rq_id   [$];
    int          rq_cyc  [$];
    int          r_first;
    int          stall_bad;

    task automatic idle_inputs();
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0; rready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [23:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit to);
        int n = 0;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        #1;
        while (awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        to = n >= 50;
        @(posedge clk); #1 awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] base, input logic [31:0] step, input int beats,
                          input logic [3:0] strb, output bit to);
        to = 0;
        for (int i = 0; i < beats; i++) begin
            int n = 0;
            @(negedge clk);
            wdata = base + step * i; wstrb = strb; wlast = (i == beats - 1); wvalid = 1;
            #1;
            while (wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
            if (n >= 50) to = 1;
            @(posedge clk); #1 wvalid = 0; wlast = 0;
        end
    endtask

    task automatic b_get(output logic [3:0] id, output logic [1:0] resp, output bit to);
        int n = 0;
        @(negedge clk);
        bready = 1; #1;
        while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        to = n >= 50;
        id = bid; resp = bresp;
        @(posedge clk); #1 bready = 0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [23:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           output int c0, output bit to);
        int n = 0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        #1;
        while (arready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        to = n >= 50;
        c0 = cyc;
        @(posedge clk); #1 arvalid = 0;
    endtask

    task automatic r_collect(input bit toggle, output bit to);
        bit prev_stall = 0;
        bit done = 0;
        logic [38:0] snap = '0;
        rq_data.delete(); rq_last.delete(); rq_resp.delete(); rq_id.delete(); rq_cyc.delete();
        r_first = -1; stall_bad = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rready = toggle ? (i % 2 == 1) : 1'b1;
            #1;
            if (outst > max_out) max_out = outst;
            if (rvalid === 1'b1) begin
                if (r_first < 0) r_first = cyc;
                if (prev_stall && ({rdata, rid, rresp, rlast} !== snap)) stall_bad++;
                if (rready) begin
                    rq_data.push_back(rdata); rq_last.push_back(rlast); rq_resp.push_back(rresp);
                    rq_id.push_back(rid); rq_cyc.push_back(cyc);
                end
                prev_stall = !rready;
                snap = {rdata, rid, rresp, rlast};
                if (rready && rlast === 1'b1) begin
                    @(posedge clk);
                    done = 1;
                end
            end else begin
                if (prev_stall) stall_bad++;
                prev_stall = 0;
            end
        end
        #1 rready = 0;
        to = !done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (awready !== 1'b0) begin fails++; $display("FAIL reset_awready: got %b want 0", awready); end
        tests++; if (arready !== 1'b0) begin fails++; $display("FAIL reset_arready: got %b want 0", arready); end
        tests++; if (wready !== 1'b0) begin fails++; $display("FAIL reset_wready: got %b want 0", wready); end
        tests++; if ({bvalid, rvalid} !== 2'b00) begin fails++; $display("FAIL reset_valids: got %b want 00", {bvalid, rvalid}); end
        tests++; if ({ram_en, ram_we} !== 5'd0) begin fails++; $display("FAIL reset_ram_en_we: got %h want 0", {ram_en, ram_we}); end
        tests++; if ({bid, bresp, rid, rdata, rresp, rlast, ram_addr, ram_d} !== '0) begin
            fails++; $display("FAIL reset_outputs_zero: got %h want 0", {bid, bresp, rid, rdata, rresp, rlast, ram_addr, ram_d});
        end
        rst_n = 1'b1;
        @(negedge clk);
        awvalid = 1; awaddr = 24'h0; awsize = 3'd2;
        #1;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL reset_aw_accept: got %b want 1", awready); end
        tests++; if (arready !== 1'b0) begin fails++; $display("FAIL reset_ar_quiet: got %b want 0", arready); end
        awvalid = 0;
    endtask

    task automatic test_write_incr();
        bit t1, t2, t3;
        logic [3:0] id; logic [1:0] resp;
        wr_log.delete();
        aw_send(4'd5, 24'h100, 8'd3, 3'd2, 2'b01, t1);
        w_send(32'hA0, 32'h1, 4, 4'hF, t2);
        @(negedge clk); #1;
        tests++; if (bvalid !== 1'b1) begin fails++; $display("FAIL wr_bvalid_held: got %b want 1", bvalid); end
        b_get(id, resp, t3);
        tests++; if ({t1, t2, t3} != 3'b000) begin fails++; $display("FAIL wr_timeout: got %b want 000", {t1, t2, t3}); end
        tests++; if (wr_log.size() != 4) begin fails++; $display("FAIL wr_count: got %0d want 4", wr_log.size()); end
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            logic [57:0] want;
            want = {22'h40 + 22'(i), 32'hA0 + 32'(i), 4'hF};
            tests++; if (wr_log[i] !== want) begin fails++; $display("FAIL wr_beat%0d: got %h want %h", i, wr_log[i], want); end
        end
        tests++; if (id !== 4'd5) begin fails++; $display("FAIL wr_bid: got %h want 5", id); end
        tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b want 00", resp); end
    endtask

    task automatic test_read_stream();
        bit t1, t2; int c0;
        ar_send(4'd6, 24'h100, 8'd3, 3'd2, 2'b01, c0, t1);
        r_collect(1'b0, t2);
        tests++; if ({t1, t2} != 2'b00) begin fails++; $display("FAIL rd_timeout: got %b want 00", {t1, t2}); end
        tests++; if (r_first - c0 != 2) begin fails++; $display("FAIL rd_latency: got %0d want 2", r_first - c0); end
        tests++; if (rq_data.size() != 4) begin fails++; $display("FAIL rd_count: got %0d want 4", rq_data.size()); end
        for (int i = 0; i < 4 && i < rq_data.size(); i++) begin
            logic [38:0] got, want;
            got  = {rq_data[i], rq_id[i], rq_resp[i], rq_last[i]};
            want = {32'hA0 + 32'(i), 4'd6, 2'b00, i == 3};
            tests++; if (got !== want) begin fails++; $display("FAIL rd_beat%0d: got %h want %h", i, got, want); end
            tests++; if (rq_cyc[i] != r_first + i) begin fails++; $display("FAIL rd_b2b%0d: got cycle %0d want %0d", i, rq_cyc[i], r_first + i); end
        end
    endtask

    task automatic test_read_backpressure();
        bit t1, t2; int c0;
        max_out = 0;
        ar_send(4'd2, 24'h100, 8'd3, 3'd2, 2'b01, c0, t1);
        r_collect(1'b1, t2);
        tests++; if ({t1, t2} != 2'b00) begin fails++; $display("FAIL bp_timeout: got %b want 00", {t1, t2}); end
        tests++; if (rq_data.size() != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", rq_data.size()); end
        for (int i = 0; i < 4 && i < rq_data.size(); i++) begin
            tests++; if ({rq_data[i], rq_last[i]} !== {32'hA0 + 32'(i), i == 3}) begin
                fails++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, rq_data[i], rq_last[i], 32'hA0 + 32'(i), i == 3);
            end
        end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
        tests++; if (max_out > 2) begin fails++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    endtask

    task automatic test_size_error();
        bit t1, t2, t3, t4, t5; int c0;
        logic [3:0] id; logic [1:0] resp;
        wr_log.delete();
        aw_send(4'd7, 24'h180, 8'd1, 3'd1, 2'b01, t1);
        w_send(32'hDEAD0000, 32'h1, 2, 4'hF, t2);
        b_get(id, resp, t3);
        tests++; if (wr_log.size() != 0) begin fails++; $display("FAIL err_no_write: got %0d writes want 0", wr_log.size()); end
        tests++; if ({id, resp} !== {4'd7, 2'b10}) begin fails++; $display("FAIL err_bresp: got %h/%b want 7/10", id, resp); end
        ar_send(4'd8, 24'h100, 8'd1, 3'd1, 2'b01, c0, t4);
        r_collect(1'b0, t5);
        tests++; if ({t1, t2, t3, t4, t5} != 5'd0) begin fails++; $display("FAIL err_timeout: got %b want 00000", {t1, t2, t3, t4, t5}); end
        tests++; if (rq_data.size() != 2) begin fails++; $display("FAIL err_rd_count: got %0d want 2", rq_data.size()); end
        for (int i = 0; i < 2 && i < rq_data.size(); i++) begin
            logic [38:0] got, want;
            got  = {rq_data[i], rq_id[i], rq_resp[i], rq_last[i]};
            want = {32'h0, 4'd8, 2'b10, i == 1};
            tests++; if (got !== want) begin fails++; $display("FAIL err_rd_beat%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_round_robin();
        bit t1, t2, t3, t4, t5; int c0;
        logic [3:0] id; logic [1:0] resp;
        do_reset();
        wr_log.delete();
        @(negedge clk);
        awid = 4'd3; awaddr = 24'h200; awlen = 8'd2; awsize = 3'd2; awburst = 2'b00; awvalid = 1;
        arid = 4'd9; araddr = 24'h100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        #1;
        tests++; if ({awready, arready} !== 2'b10) begin fails++; $display("FAIL rr_first_write: got %b want 10", {awready, arready}); end
        @(posedge clk); #1 awvalid = 0;
        w_send(32'h11, 32'h11, 3, 4'hF, t1);
        b_get(id, resp, t2);
        tests++; if ({id, resp} !== {4'd3, 2'b00}) begin fails++; $display("FAIL rr_fixed_b: got %h/%b want 3/00", id, resp); end
        tests++; if (wr_log.size() != 3) begin fails++; $display("FAIL rr_fixed_count: got %0d want 3", wr_log.size()); end
        for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
            logic [57:0] want;
            want = {22'h80, 32'h11 * 32'(i + 1), 4'hF};
            tests++; if (wr_log[i] !== want) begin fails++; $display("FAIL rr_fixed_beat%0d: got %h want %h", i, wr_log[i], want); end
        end
        @(negedge clk);
        awid = 4'd4; awaddr = 24'h300; awlen = 8'd0; awburst = 2'b01; awvalid = 1;
        #1;
        tests++; if ({awready, arready} !== 2'b01) begin fails++; $display("FAIL rr_then_read: got %b want 01", {awready, arready}); end
        c0 = cyc;
        @(posedge clk); #1 arvalid = 0;
        r_collect(1'b0, t3);
        tests++; if (rq_data.size() != 1 || r_first - c0 != 2) begin
            fails++; $display("FAIL rr_read_shape: got %0d beats at +%0d want 1 at +2", rq_data.size(), r_first - c0);
        end
        if (rq_data.size() > 0) begin
            tests++; if ({rq_data[0], rq_id[0], rq_last[0]} !== {32'hA0, 4'd9, 1'b1}) begin
                fails++; $display("FAIL rr_read_beat: got %h/%h/%b want a0/9/1", rq_data[0], rq_id[0], rq_last[0]);
            end
        end
        @(negedge clk); #1;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL rr_write_again: got %b want 1", awready); end
        @(posedge clk); #1 awvalid = 0;
        w_send(32'h55, 32'h0, 1, 4'hF, t4);
        b_get(id, resp, t5);
        tests++; if ({t1, t2, t3, t4, t5} != 5'd0) begin fails++; $display("FAIL rr_timeout: got %b want 00000", {t1, t2, t3, t4, t5}); end
        tests++; if (id !== 4'd4 || wr_log.size() != 4) begin fails++; $display("FAIL rr_second_write: got id %h, %0d writes want 4, 4", id, wr_log.size()); end
        if (wr_log.size() == 4) begin
            tests++; if (wr_log[3] !== {22'hC0, 32'h55, 4'hF}) begin fails++; $display("FAIL rr_second_beat: got %h want %h", wr_log[3], {22'hC0, 32'h55, 4'hF}); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_incr();
        test_read_stream();
        test_read_backpressure();
        test_size_error();
        test_round_robin();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
